ase_hssi_tx_pkt_buffer: RTL and testbench

ASE_HSSI_TX_PKT_BUFFER -- requirements
Module: ase_hssi_tx_pkt_buffer

---
 rtl/ase_hssi_tx_pkt_buffer.sv | 147 ++++++++++++++
 tb/tb_ase_hssi_tx_pkt_buffer.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ase_hssi_tx_pkt_buffer.sv
// Store-and-forward AXI-S TX packet buffer between an AFU and the HSSI emulator.
// Whole packets are committed before being forwarded; oversize packets are dropped.
module ase_hssi_tx_pkt_buffer #(
    parameter int TDATA_WIDTH = 512,
    parameter int TUSER_WIDTH = 10,
    parameter int TKEEP_WIDTH = 64,
    parameter int DEPTH       = 64,
    parameter int MAX_PKTS    = 16
) (
    input  logic                           clk,
    input  logic                           SoftReset,
    input  logic                           in_tvalid,
    input  logic                           in_tlast,
    input  logic [TDATA_WIDTH-1:0]         in_tdata,
    input  logic [TKEEP_WIDTH-1:0]         in_tkeep,
    input  logic [TUSER_WIDTH-1:0]         in_tuser,
    output logic                           in_tready,
    output logic                           out_tvalid,
    output logic                           out_tlast,
    output logic [TDATA_WIDTH-1:0]         out_tdata,
    output logic [TKEEP_WIDTH-1:0]         out_tkeep,
    output logic [TUSER_WIDTH-1:0]         out_tuser,
    input  logic                           out_tready,
    input  logic                           tx_pause,
    output logic [$clog2(MAX_PKTS+1)-1:0]  pkt_count,
    output logic [31:0]                    drop_count,
    output logic [$clog2(DEPTH+1)-1:0]     level
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(MAX_PKTS + 1);
    localparam int WW = TDATA_WIDTH + TKEEP_WIDTH + TUSER_WIDTH + 1;
    localparam logic [PW-1:0] FULL_LVL = PW'(DEPTH);
    localparam logic [CW-1:0] MAX_CNT  = CW'(MAX_PKTS);

    typedef enum logic {ACCEPT, DROP} in_state_t;
    typedef enum logic {IDLE, SEND}   out_state_t;

    in_state_t  in_state, in_next;
    out_state_t out_state, out_next;

    logic [WW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr, pkt_start, pend;
    logic [WW-1:0] rd_word;
    logic          wr_fire, store, commit, overflow;
    logic          out_fire, pop, out_load, last_loaded;

    assign level    = wr_ptr - rd_ptr;
    assign pend     = wr_ptr - pkt_start;
    assign wr_fire  = in_tvalid && in_tready;
    assign store    = wr_fire && (in_state == ACCEPT);
    assign commit   = store && in_tlast;
    // A packet that alone fills the buffer can never be committed.
    assign overflow = (in_state == ACCEPT) && (pend == FULL_LVL);

    assign rd_word  = mem[rd_ptr[AW-1:0]];
    assign out_fire = out_tvalid && out_tready;
    assign pop      = out_fire && out_tlast;
    assign out_load = (out_state == SEND) && !last_loaded && (!out_tvalid || out_tready);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        in_tready = 1'b0;
        in_next   = in_state;
        if (!SoftReset) begin
            case (in_state)
                ACCEPT: in_tready = (level < FULL_LVL) && (pkt_count < MAX_CNT);
                DROP:   in_tready = 1'b1;
                default: in_tready = 1'b0;
            endcase
        end
        case (in_state)
            ACCEPT: if (overflow) in_next = DROP;
            DROP:   if (wr_fire && in_tlast) in_next = ACCEPT;
            default: in_next = ACCEPT;
        endcase
    end

    always_comb begin
        out_next = out_state;
        case (out_state)
            IDLE: if ((pkt_count != '0) && !tx_pause) out_next = SEND;
            SEND: if (pop) out_next = IDLE;
            default: out_next = IDLE;
        endcase
    end

    // NOTE: beat storage is deliberately left unreset; pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (store)
            mem[wr_ptr[AW-1:0]] <= {in_tlast, in_tuser, in_tkeep, in_tdata};
    end

    always_ff @(posedge clk) begin
        if (SoftReset) begin
            in_state   <= ACCEPT;
            wr_ptr     <= '0;
            pkt_start  <= '0;
            drop_count <= '0;
        end else begin
            in_state <= in_next;
            if (overflow) begin
                wr_ptr <= pkt_start;
                if (drop_count != '1)
                    drop_count <= drop_count + 32'd1;
            end else if (store) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (in_tlast)
                    pkt_start <= wr_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (SoftReset) begin
            out_state   <= IDLE;
            rd_ptr      <= '0;
            last_loaded <= 1'b0;
            out_tvalid  <= 1'b0;
            out_tlast   <= 1'b0;
            out_tdata   <= '0;
            out_tkeep   <= '0;
            out_tuser   <= '0;
            pkt_count   <= '0;
        end else begin
            out_state <= out_next;
            if (out_load) begin
                {out_tlast, out_tuser, out_tkeep, out_tdata} <= rd_word;
                out_tvalid <= 1'b1;
                rd_ptr     <= rd_ptr + 1'b1;
            end else if (out_fire) begin
                out_tvalid <= 1'b0;
            end
            if (out_state == IDLE)
                last_loaded <= 1'b0;
            else if (out_load)
                last_loaded <= rd_word[WW-1];
            case ({commit, pop})
                2'b10:   pkt_count <= pkt_count + 1'b1;
                2'b01:   pkt_count <= pkt_count - 1'b1;
                default: pkt_count <= pkt_count;
            endcase
        end
    end

endmodule

// File: tb/tb_ase_hssi_tx_pkt_buffer.sv
// Scoreboard bench for ase_hssi_tx_pkt_buffer: whole packets are queued as expected
// output when their tlast is accepted; a monitor pops and compares every output beat.
module tb_ase_hssi_tx_pkt_buffer;

    localparam int TDW   = 512;
    localparam int TUW   = 10;
    localparam int TKW   = 64;
    localparam int DEPTH = 64;
    localparam int MAXP  = 16;

    typedef struct packed {
        logic           last;
        logic [TUW-1:0] user;
        logic [TKW-1:0] keep;
        logic [TDW-1:0] data;
    } beat_t;

    logic                        clk = 1'b0;
    logic                        SoftReset;
    logic                        in_tvalid, in_tlast, in_tready;
    logic [TDW-1:0]              in_tdata;
    logic [TKW-1:0]              in_tkeep;
    logic [TUW-1:0]              in_tuser;
    logic                        out_tvalid, out_tlast, out_tready, tx_pause;
    logic [TDW-1:0]              out_tdata;
    logic [TKW-1:0]              out_tkeep;
    logic [TUW-1:0]              out_tuser;
    logic [$clog2(MAXP+1)-1:0]   pkt_count;
    logic [31:0]                 drop_count;
    logic [$clog2(DEPTH+1)-1:0]  level;

    int    tests = 0;
    int    fails = 0;
    int    beats_seen = 0;
    int    model_drops = 0;
    beat_t exp_q[$];

    ase_hssi_tx_pkt_buffer #(
        .TDATA_WIDTH(TDW), .TUSER_WIDTH(TUW), .TKEEP_WIDTH(TKW),
        .DEPTH(DEPTH), .MAX_PKTS(MAXP)
    ) dut (
        .clk(clk), .SoftReset(SoftReset),
        .in_tvalid(in_tvalid), .in_tlast(in_tlast), .in_tdata(in_tdata),
        .in_tkeep(in_tkeep), .in_tuser(in_tuser), .in_tready(in_tready),
        .out_tvalid(out_tvalid), .out_tlast(out_tlast), .out_tdata(out_tdata),
        .out_tkeep(out_tkeep), .out_tuser(out_tuser), .out_tready(out_tready),
        .tx_pause(tx_pause), .pkt_count(pkt_count), .drop_count(drop_count),
        .level(level)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic abort(input string name);
        tests++;
        fails++;
        $display("FAIL %s: timed out", name);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic beat_t rand_beat(input bit last);
        beat_t b;
        for (int i = 0; i < TDW / 32; i++) b.data[i*32 +: 32] = $urandom();
        b.keep = {$urandom(), $urandom()};
        b.user = TUW'($urandom());
        b.last = last;
        return b;
    endfunction

    // Reference rule: a packet longer than DEPTH beats is dropped, any other is forwarded.
    task automatic send_pkt(input int len, input int max_gap, input bit with_tlast);
        beat_t pb[$];
        beat_t b;
        bit    acc;
        int    n;
        for (int i = 0; i < len; i++) begin
            b = rand_beat(with_tlast && (i == len - 1));
            in_tvalid = 1'b0;
            repeat ($urandom_range(0, max_gap)) tick();
            {in_tlast, in_tuser, in_tkeep, in_tdata} = b;
            in_tvalid = 1'b1;
            acc = 1'b0;
            n = 0;
            while (!acc) begin
                @(negedge clk);
                acc = in_tready;
                tick();
                n++;
                if (!acc && n > 3000) abort("in_accept");
            end
            pb.push_back(b);
        end
        in_tvalid = 1'b0;
        in_tlast  = 1'b0;
        if (with_tlast) begin
            if (len <= DEPTH) foreach (pb[i]) exp_q.push_back(pb[i]);
            else model_drops++;
        end
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || out_tvalid) && n < budget) begin
            tick();
            n++;
        end
        check("drain_queue_left", exp_q.size(), 0);
    endtask

    // Output monitor: pops the scoreboard on every handshake and checks stall stability.
    initial begin
        beat_t e, cur, held;
        bit    stalled = 1'b0;
        forever begin
            @(negedge clk);
            cur = {out_tlast, out_tuser, out_tkeep, out_tdata};
            if (SoftReset) begin
                stalled = 1'b0;
            end else begin
                if (stalled && out_tvalid) begin
                    tests++;
                    if (cur !== held) begin
                        fails++;
                        $display("FAIL hold_stable: data %h tlast %0b expected data %h tlast %0b",
                                 cur.data, cur.last, held.data, held.last);
                    end
                end
                if (out_tvalid && out_tready) begin
                    beats_seen++;
                    tests++;
                    if (exp_q.size() == 0) begin
                        fails++;
                        $display("FAIL out_beat: unexpected beat data %h", cur.data);
                    end else begin
                        e = exp_q.pop_front();
                        if (cur !== e) begin
                            fails++;
                            $display("FAIL out_beat: got data %h keep %h user %h last %0b expected data %h keep %h user %h last %0b",
                                     cur.data, cur.keep, cur.user, cur.last, e.data, e.keep, e.user, e.last);
                        end
                    end
                end
                stalled = out_tvalid && !out_tready;
                held    = cur;
            end
        end
    end

    initial begin
        #3000000;
        abort("watchdog");
    end

    initial begin
        int  k, b0, len;
        bit  done;
        SoftReset = 1'b1;
        in_tvalid = 1'b0; in_tlast = 1'b0;
        in_tdata = '0; in_tkeep = '0; in_tuser = '0;
        out_tready = 1'b0; tx_pause = 1'b0;

        // Reset state
        repeat (3) tick();
        check("rst_in_tready", in_tready, 0);
        check("rst_level", level, 0);
        check("rst_pkt_count", pkt_count, 0);
        check("rst_drop_count", drop_count, 0);
        check("rst_out_tvalid", out_tvalid, 0);
        check("rst_out_tlast", out_tlast, 0);
        check("rst_out_tdata_zero", {63'd0, out_tdata == '0}, 1);
        SoftReset = 1'b0;
        tick();
        check("post_rst_in_tready", in_tready, 1);

        // Single 3-beat packet, latency and count
        out_tready = 1'b1;
        send_pkt(3, 0, 1'b1);
        check("commit_pkt_count", pkt_count, 1);
        k = 0;
        while (!out_tvalid && k < 10) begin
            tick();
            k++;
        end
        check("first_beat_latency", k, 2);
        wait_drain(100);
        check("drained_pkt_count", pkt_count, 0);

        // Oversize packet dropped, next packet intact
        b0 = beats_seen;
        send_pkt(DEPTH + 5, 0, 1'b1);
        repeat (4) tick();
        check("oversize_drop_count", drop_count, 1);
        check("oversize_no_output", beats_seen, b0);
        check("oversize_level", level, 0);
        send_pkt(2, 1, 1'b1);
        wait_drain(100);
        check("after_drop_beats", beats_seen, b0 + 2);

        // Pause held off between packets only
        tx_pause = 1'b1;
        b0 = beats_seen;
        send_pkt(4, 0, 1'b1);
        send_pkt(4, 0, 1'b1);
        repeat (10) tick();
        check("paused_no_beats", beats_seen, b0);
        check("paused_pkt_count", pkt_count, 2);
        tx_pause = 1'b0;
        k = 0;
        while (beats_seen == b0 && k < 20) begin
            tick();
            k++;
        end
        tx_pause = 1'b1;
        repeat (20) tick();
        check("pause_mid_pkt_beats", beats_seen, b0 + 4);
        check("pause_mid_pkt_count", pkt_count, 1);
        tx_pause = 1'b0;
        wait_drain(100);
        check("pause_release_beats", beats_seen, b0 + 8);

        // MAX_PKTS committed packets block input
        out_tready = 1'b0;
        for (int i = 0; i < MAXP; i++) send_pkt(1, 0, 1'b1);
        check("max_pkt_count", pkt_count, MAXP);
        check("max_in_tready", in_tready, 0);
        out_tready = 1'b1;
        k = 0;
        while (!in_tready && k < 5) begin
            tick();
            k++;
        end
        check("max_release_in_tready", in_tready, 1);
        wait_drain(200);

        // Random traffic with random backpressure
        done = 1'b0;
        fork
            begin
                for (int p = 0; p < 200; p++) begin
                    len = ($urandom_range(0, 19) == 0) ? DEPTH + $urandom_range(1, 4)
                                                       : $urandom_range(1, 8);
                    send_pkt(len, 2, 1'b1);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    tick();
                    out_tready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_tready = 1'b1;
        wait_drain(3000);
        check("random_level", level, 0);
        check("random_pkt_count", pkt_count, 0);
        check("random_drop_count", drop_count, model_drops);

        // Reset with a partial packet stored
        b0 = beats_seen;
        send_pkt(10, 0, 1'b0);
        check("partial_level", level, 10);
        SoftReset = 1'b1;
        tick();
        check("mid_rst_level", level, 0);
        check("mid_rst_pkt_count", pkt_count, 0);
        check("mid_rst_out_tvalid", out_tvalid, 0);
        check("mid_rst_drop_count", drop_count, 0);
        SoftReset = 1'b0;
        exp_q.delete();
        tick();
        check("after_rst_in_tready", in_tready, 1);
        repeat (20) tick();
        check("no_stale_beats", beats_seen, b0);
        send_pkt(3, 1, 1'b1);
        wait_drain(100);
        check("after_rst_beats", beats_seen, b0 + 3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
